// File: rtl/pp_row_accumulator_seq_if.sv
// Handshake bundle for pp_row_accumulator_seq: matrix in, product out, plus busy status.
// The producer/consumer side uses the master modport; the accumulator uses slave.
interface pp_row_accumulator_seq_if #(
  parameter int unsigned N = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [N*N-1:0]   pp_in;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-1:0]   product;
  logic             busy;

  modport master (
    output in_valid,
    output pp_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  product,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  pp_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output product,
    output busy
  );
endinterface

// File: rtl/pp_row_accumulator_seq.sv
// Multi-cycle partial-product row accumulator with optional column truncation.
// Optional feature: define PP_ROUND_COMP_EN to add 2^(TRUNC_COL-1) as truncation compensation.
module pp_row_accumulator_seq #(
  parameter int unsigned N            = 8,
  parameter int unsigned ROWS_PER_CYC = 2,
  parameter int unsigned TRUNC_COL    = 0
) (
  input logic                     clk,
  input logic                     rst_n,
  pp_row_accumulator_seq_if.slave bus
);

  localparam int unsigned     RowW    = $clog2(N + 1);
  localparam logic [RowW-1:0] LastRow = RowW'(N - ROWS_PER_CYC);
  localparam logic [RowW-1:0] RowStep = RowW'(ROWS_PER_CYC);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic logic [N*N-1:0] trunc_mask();
    logic [N*N-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        m[i*N+j] = ((i + j) >= TRUNC_COL);
      end
    end
    return m;
  endfunction

  localparam logic [N*N-1:0] Mask = trunc_mask();

`ifdef PP_ROUND_COMP_EN
  // Single set bit at TRUNC_COL-1; all zero when nothing is truncated.
  function automatic logic [2*N-1:0] round_const();
    logic [2*N-1:0] c;
    c = '0;
    for (int unsigned b = 0; b < 2 * N; b++) begin
      c[b] = ((b + 1) == TRUNC_COL);
    end
    return c;
  endfunction

  localparam logic [2*N-1:0] RoundConst = round_const();
`endif

  logic [1:0]       state_q, state_d;
  logic [N*N-1:0]   mat_q, mat_d;
  logic [2*N-1:0]   acc_q, acc_d;
  logic [2*N-1:0]   prod_q, prod_d;
  logic [RowW-1:0]  row_q, row_d;
  logic [2*N-1:0]   row_sum;
  logic [2*N-1:0]   acc_sum;
  int unsigned      idx;

  // Rows row_q..row_q+ROWS_PER_CYC-1, each weighted by its row index.
  always_comb begin
    row_sum = '0;
    idx     = 0;
    for (int unsigned k = 0; k < ROWS_PER_CYC; k++) begin
      idx     = 32'(row_q) + k;
      row_sum = row_sum + ({{N{1'b0}}, mat_q[idx*N +: N]} << idx);
    end
    acc_sum = acc_q + row_sum;
  end

  always_comb begin
    state_d = state_q;
    mat_d   = mat_q;
    acc_d   = acc_q;
    row_d   = row_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mat_d   = bus.pp_in & Mask;
          acc_d   = '0;
          row_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = acc_sum;
        row_d = row_q + RowStep;
        if (row_q == LastRow) begin
`ifdef PP_ROUND_COMP_EN
          acc_d = acc_sum + RoundConst;
`else
          acc_d = acc_sum;
`endif
          prod_d  = acc_d;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mat_q   <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      row_q   <= row_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == ACC) || (state_q == DONE);
  assign bus.product   = prod_q;

endmodule

// File: tb/tb_pp_row_accumulator_seq.sv
// Self-checking bench for pp_row_accumulator_seq: directed scenarios plus randomized traffic
// checked every cycle against a column-sum reference model.
module tb_pp_row_accumulator_seq;

  localparam int N = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pp_row_accumulator_seq_if #(.N(N)) bus0 ();
  pp_row_accumulator_seq_if #(.N(N)) bus7 ();

  pp_row_accumulator_seq #(.N(N), .ROWS_PER_CYC(2), .TRUNC_COL(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  pp_row_accumulator_seq #(.N(N), .ROWS_PER_CYC(2), .TRUNC_COL(7)) dut7 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus7)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Row i carries b gated by a[i]; the true sum is a*b.
  function automatic logic [N*N-1:0] and_pp(input logic [7:0] a, input logic [7:0] b);
    logic [N*N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) m[i*N +: N] = b & {N{a[i]}};
    return m;
  endfunction

  // Reference: sum each surviving bit at weight 2^(i+j), plus rounding constant if enabled.
  function automatic logic [15:0] model(input logic [N*N-1:0] m, input int tc);
    logic [31:0] s;
    s = 0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (m[i*N+j] && (i + j) >= tc) s = s + (32'd1 << (i + j));
      end
    end
`ifdef PP_ROUND_COMP_EN
    if (tc > 0) s = s + (32'd1 << (tc - 1));
`endif
    return s[15:0];
  endfunction

  // Transaction-level model of dut0: job accepted at edge m_start, result visible 4 edges later.
  bit          m_active = 1'b0;
  int          m_start  = 0;
  logic [15:0] m_val    = '0;
  logic [15:0] m_last   = '0;
  logic        exp_ov;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_last   = '0;
    end
    exp_ov = m_active && ((cyc - m_start) >= 4);
    if (chk_en) begin
      chk("in_ready", 32'(bus0.in_ready), 32'(!m_active));
      chk("out_valid", 32'(bus0.out_valid), 32'(exp_ov));
      chk("busy", 32'(bus0.busy), 32'(m_active));
      chk("product", 32'(bus0.product), 32'(exp_ov ? m_val : m_last));
    end
    if (rst_n) begin
      if (!m_active && bus0.in_valid) begin
        m_active = 1'b1;
        m_start  = cyc + 1;
        m_val    = model(bus0.pp_in, 0);
      end else if (exp_ov && bus0.out_ready) begin
        m_active = 1'b0;
        m_last   = m_val;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [N*N-1:0] m, output int acc_cyc);
    bus0.pp_in    = m;
    bus0.in_valid = 1'b1;
    for (int i = 0; i < 50 && !bus0.in_ready; i++) tick();
    if (!bus0.in_ready) begin
      total++; bad++;
      $display("FAIL send0_timeout: in_ready stayed 0, required 1");
    end
    tick();
    acc_cyc       = cyc;
    bus0.in_valid = 1'b0;
  endtask

  task automatic wait_ov0(output int at_cyc);
    for (int i = 0; i < 50 && !bus0.out_valid; i++) tick();
    if (!bus0.out_valid) begin
      total++; bad++;
      $display("FAIL wait_ov0_timeout: out_valid stayed 0, required 1");
    end
    at_cyc = cyc;
  endtask

  task automatic send7(input logic [N*N-1:0] m, output int acc_cyc);
    bus7.pp_in    = m;
    bus7.in_valid = 1'b1;
    for (int i = 0; i < 50 && !bus7.in_ready; i++) tick();
    if (!bus7.in_ready) begin
      total++; bad++;
      $display("FAIL send7_timeout: in_ready stayed 0, required 1");
    end
    tick();
    acc_cyc       = cyc;
    bus7.in_valid = 1'b0;
  endtask

  task automatic wait_ov7(output int at_cyc);
    for (int i = 0; i < 50 && !bus7.out_valid; i++) tick();
    if (!bus7.out_valid) begin
      total++; bad++;
      $display("FAIL wait_ov7_timeout: out_valid stayed 0, required 1");
    end
    at_cyc = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, v, prev;
    bus0.in_valid = 1'b0; bus0.pp_in = '0; bus0.out_ready = 1'b1;
    bus7.in_valid = 1'b0; bus7.pp_in = '0; bus7.out_ready = 1'b1;
    chk_en = 1'b1;
    rst_n  = 1'b0;

    // Reset values, then held after release while idle.
    repeat (3) tick();
    chk("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    chk("rst_product", 32'(bus0.product), 32'd0);
    chk("rst_busy", 32'(bus0.busy), 32'd0);
    chk("rst_in_ready", 32'(bus0.in_ready), 32'd1);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_in_ready", 32'(bus0.in_ready), 32'd1);
    chk("post_rst_product", 32'(bus0.product), 32'd0);

    // Exact full scale.
    send0(and_pp(8'hFF, 8'hFF), a);
    wait_ov0(v);
    chk("t2_latency", 32'(v - a), 32'd4);
    chk("t2_product", 32'(bus0.product), 32'hFE01);
    tick();
    chk("t2_released", 32'(bus0.out_valid), 32'd0);

    // Backpressure with an ignored second request.
    bus0.out_ready = 1'b0;
    send0(and_pp(8'h0D, 8'h0B), a);
    wait_ov0(v);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        bus0.pp_in    = and_pp(8'hFF, 8'h01);
        bus0.in_valid = 1'b1;
      end
      if (k == 2) bus0.in_valid = 1'b0;
      tick();
      chk("t3_product", 32'(bus0.product), 32'h008F);
      chk("t3_out_valid", 32'(bus0.out_valid), 32'd1);
      chk("t3_in_ready", 32'(bus0.in_ready), 32'd0);
    end
    bus0.out_ready = 1'b1;
    tick();
    chk("t3_in_ready_after", 32'(bus0.in_ready), 32'd1);
    chk("t3_product_kept", 32'(bus0.product), 32'h008F);
    tick();
    chk("t3_second_ignored", 32'(bus0.busy), 32'd0);

    // Truncation on the TRUNC_COL=7 instance.
    send7(and_pp(8'hFF, 8'hFF), a);
    wait_ov7(v);
    chk("t4_latency", 32'(v - a), 32'd4);
`ifdef PP_ROUND_COMP_EN
    chk("t4_product", 32'(bus7.product), 32'hFB40);
`else
    chk("t4_product", 32'(bus7.product), 32'hFB00);
`endif
    tick();

    // Reset during the second ACC cycle.
    send0(and_pp(8'hAA, 8'h55), a);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_out_valid", 32'(bus0.out_valid), 32'd0);
    chk("t5_busy", 32'(bus0.busy), 32'd0);
    chk("t5_in_ready", 32'(bus0.in_ready), 32'd1);
    chk("t5_product", 32'(bus0.product), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    send0(and_pp(8'h03, 8'h05), a);
    wait_ov0(v);
    chk("t5_latency", 32'(v - a), 32'd4);
    chk("t5_after_product", 32'(bus0.product), 32'h000F);
    tick();

    // Streaming: accepts every 6 cycles, per-cycle values covered by the model.
    bus0.out_ready = 1'b1;
    bus0.in_valid  = 1'b1;
    prev = 0;
    for (int r = 0; r < 6; r++) begin
      bus0.pp_in = r[0] ? and_pp(8'hC3, 8'h5A) : and_pp(8'h7F, 8'h81);
      for (int i = 0; i < 50 && !bus0.in_ready; i++) tick();
      tick();
      if (r > 0) chk("t6_spacing", 32'(cyc - prev), 32'd6);
      prev = cyc;
    end
    bus0.in_valid = 1'b0;
    repeat (8) tick();

    // Randomized traffic, including raw non-AND matrices and one reset pulse.
    for (int i = 0; i < 1500; i++) begin
      bus0.in_valid  = ($urandom_range(0, 2) == 0);
      bus0.out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 1)
        bus0.pp_in = and_pp(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      else
        bus0.pp_in = {$urandom, $urandom};
      if (i == 700) rst_n = 1'b0;
      if (i == 702) rst_n = 1'b1;
      tick();
    end
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b1;
    repeat (10) tick();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
